// File: rtl/decode_queue_pkg.sv
// MIPS opcode/function codes and control-bundle bit positions shared by the
// decode queue and its head classifier.
package decode_queue_pkg;

  localparam int CTRL_W = 10;

  // w_ctrl_10 = {alu, unsigned, imm, byte, shift, mem, write, branch, jump, nop}
  localparam int CTRL_ALU    = 9;
  localparam int CTRL_UNS    = 8;
  localparam int CTRL_IMM    = 7;
  localparam int CTRL_BYTE   = 6;
  localparam int CTRL_SHIFT  = 5;
  localparam int CTRL_MEM    = 4;
  localparam int CTRL_WRITE  = 3;
  localparam int CTRL_BRANCH = 2;
  localparam int CTRL_JUMP   = 1;
  localparam int CTRL_NOP    = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

endpackage

// File: rtl/decode_queue_instr_decode.sv
// Combinational classifier for one instruction word: control bundle, op type,
// destination register, plus the source fields the hazard check compares.
module instr_decode
  import decode_queue_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [5:0]        op_type_o,
  output logic [4:0]        dest_o,
  output logic              reg_write_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rd;
  logic [4:0] shamt;

  assign op    = instr_i[31:26];
  assign rs_o  = instr_i[25:21];
  assign rt_o  = instr_i[20:16];
  assign rd    = instr_i[15:11];
  assign shamt = instr_i[10:6];
  assign func  = instr_i[5:0];

  always_comb begin
    ctrl_o    = '0;
    op_type_o = op;
    dest_o    = 5'd0;
    case (op)
      OP_SPECIAL: begin
        op_type_o = func;
        case (func)
          FN_JR:   ctrl_o[CTRL_JUMP] = 1'b1;
          FN_JALR: begin ctrl_o[CTRL_JUMP] = 1'b1; dest_o = rd; end
          FN_ADDU, FN_SUBU, FN_SLTU: begin
            ctrl_o[CTRL_ALU] = 1'b1; ctrl_o[CTRL_UNS] = 1'b1; dest_o = rd;
          end
          FN_MULTU, FN_DIVU: begin
            ctrl_o[CTRL_ALU] = 1'b1; ctrl_o[CTRL_UNS] = 1'b1;
          end
          FN_ADD, FN_SUB, FN_SLT: begin ctrl_o[CTRL_ALU] = 1'b1; dest_o = rd; end
          FN_MULT, FN_DIV:        ctrl_o[CTRL_ALU] = 1'b1;
          FN_SRL, FN_SRA: begin
            ctrl_o[CTRL_ALU] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1;
            ctrl_o[CTRL_SHIFT] = 1'b1; dest_o = rd;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            ctrl_o[CTRL_ALU] = 1'b1; ctrl_o[CTRL_SHIFT] = 1'b1; dest_o = rd;
          end
          // SLL with zero shift is the canonical NOP encoding
          FN_SLL: begin
            if (shamt != 5'd0) begin ctrl_o[CTRL_ALU] = 1'b1; dest_o = rd; end
            else ctrl_o[CTRL_NOP] = 1'b1;
          end
          default: ctrl_o[CTRL_NOP] = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (rt_o == RT_BLTZ || rt_o == RT_BGEZ) begin
          ctrl_o[CTRL_BRANCH] = 1'b1;
          op_type_o = {1'b0, rt_o};
        end else begin
          ctrl_o[CTRL_NOP] = 1'b1;
          op_type_o = 6'd0;
        end
      end
      OP_ADDIU, OP_SLTIU: begin
        ctrl_o[CTRL_ALU] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; ctrl_o[CTRL_UNS] = 1'b1;
        dest_o = rt_o;
      end
      OP_SLTI, OP_ORI, OP_XORI: begin
        ctrl_o[CTRL_ALU] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; dest_o = rt_o;
      end
      OP_LUI, OP_LW: begin
        ctrl_o[CTRL_MEM] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; dest_o = rt_o;
      end
      OP_LB, OP_LBU: begin
        ctrl_o[CTRL_MEM] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; ctrl_o[CTRL_BYTE] = 1'b1;
        ctrl_o[CTRL_UNS] = (op == OP_LBU);
        dest_o = rt_o;
      end
      OP_SW: begin
        ctrl_o[CTRL_MEM] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; ctrl_o[CTRL_WRITE] = 1'b1;
      end
      OP_SB: begin
        ctrl_o[CTRL_MEM] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1;
        ctrl_o[CTRL_BYTE] = 1'b1; ctrl_o[CTRL_WRITE] = 1'b1;
      end
      OP_J:   begin ctrl_o[CTRL_JUMP] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; end
      OP_JAL: begin ctrl_o[CTRL_JUMP] = 1'b1; ctrl_o[CTRL_IMM] = 1'b1; dest_o = 5'd31; end
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: ctrl_o[CTRL_BRANCH] = 1'b1;
      default: begin
        ctrl_o[CTRL_NOP] = 1'b1;
        op_type_o = 6'd0;
      end
    endcase
  end

  assign reg_write_o = (dest_o != 5'd0);

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: instruction FIFO between fetch and issue, with the
// head classified into a registered control bundle and optional load-use bubble.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                    w_clock,
  input  logic                    w_reset_n,
  input  logic                    w_flush,
  input  logic                    w_in_valid,
  output logic                    w_in_ready,
  input  logic [31:0]             w_instr_32,
  input  logic [31:0]             w_pc_32,
  output logic                    w_out_valid,
  input  logic                    w_out_ready,
  output logic [31:0]             w_out_instr_32,
  output logic [31:0]             w_out_pc_32,
  output logic [CTRL_W-1:0]       w_ctrl_10,
  output logic [5:0]              w_op_type_6,
  output logic [4:0]              w_dest_addr_5,
  output logic                    w_reg_write,
  output logic [$clog2(DEPTH):0]  w_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              out_valid_q;
  logic [31:0]       out_instr_q, out_pc_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [5:0]        op_type_q;
  logic [4:0]        dest_q;
  logic              reg_write_q;

  logic [31:0]       head_instr;
  logic [CTRL_W-1:0] head_ctrl;
  logic [5:0]        head_op_type;
  logic [4:0]        head_dest, head_rs, head_rt;
  logic              head_reg_write;
  logic              push, pop, can_load, hazard, out_is_load;

  assign head_instr = instr_mem_q[rd_ptr_q];

  instr_decode u_instr_decode (
    .instr_i     (head_instr),
    .ctrl_o      (head_ctrl),
    .op_type_o   (head_op_type),
    .dest_o      (head_dest),
    .reg_write_o (head_reg_write),
    .rs_o        (head_rs),
    .rt_o        (head_rt)
  );

  assign w_in_ready = (count_q < CNT_W'(DEPTH));
  assign push       = w_in_valid & w_in_ready;
  assign can_load   = (~out_valid_q | w_out_ready) & (count_q != '0);

  // A load in the output register whose rt feeds the head costs one bubble
  assign out_is_load = out_valid_q & ctrl_q[CTRL_MEM] & ~ctrl_q[CTRL_WRITE] &
                       (out_instr_q[31:26] != OP_LUI) & (out_instr_q[20:16] != 5'd0);
  assign hazard = HAZARD_EN & out_is_load &
                  ((head_rs == out_instr_q[20:16]) | (head_rt == out_instr_q[20:16]));
  assign pop    = can_load & ~hazard;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge w_clock) begin
    if (push && !w_flush) begin
      instr_mem_q[wr_ptr_q] <= w_instr_32;
      pc_mem_q[wr_ptr_q]    <= w_pc_32;
    end
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      ctrl_q      <= '0;
      op_type_q   <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
    end else if (w_flush) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_instr_q <= head_instr;
      out_pc_q    <= pc_mem_q[rd_ptr_q];
      ctrl_q      <= head_ctrl;
      op_type_q   <= head_op_type;
      dest_q      <= head_dest;
      reg_write_q <= head_reg_write;
    end else if (w_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign w_out_valid    = out_valid_q;
  assign w_out_instr_32 = out_instr_q;
  assign w_out_pc_32    = out_pc_q;
  assign w_ctrl_10      = ctrl_q;
  assign w_op_type_6    = op_type_q;
  assign w_dest_addr_5  = dest_q;
  assign w_reg_write    = reg_write_q;
  assign w_count        = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected bundles queued on accepted pushes,
// compared when the output handshake fires; a HAZARD_EN=0 twin gives the no-bubble reference.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr, pc;

  logic        a_in_ready, a_out_valid, a_reg_write;
  logic [31:0] a_out_instr, a_out_pc;
  logic [9:0]  a_ctrl;
  logic [5:0]  a_op;
  logic [4:0]  a_dest;
  logic [2:0]  a_count;

  logic        b_in_ready, b_out_valid, b_reg_write;
  logic [31:0] b_out_instr, b_out_pc;
  logic [9:0]  b_ctrl;
  logic [5:0]  b_op;
  logic [4:0]  b_dest;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .HAZARD_EN(1'b1)) u_dut (
    .w_clock(clk), .w_reset_n(rst_n), .w_flush(flush),
    .w_in_valid(in_valid), .w_in_ready(a_in_ready),
    .w_instr_32(instr), .w_pc_32(pc),
    .w_out_valid(a_out_valid), .w_out_ready(out_ready),
    .w_out_instr_32(a_out_instr), .w_out_pc_32(a_out_pc),
    .w_ctrl_10(a_ctrl), .w_op_type_6(a_op), .w_dest_addr_5(a_dest),
    .w_reg_write(a_reg_write), .w_count(a_count)
  );

  decode_queue #(.DEPTH(4), .HAZARD_EN(1'b0)) u_dut_nohaz (
    .w_clock(clk), .w_reset_n(rst_n), .w_flush(flush),
    .w_in_valid(in_valid), .w_in_ready(b_in_ready),
    .w_instr_32(instr), .w_pc_32(pc),
    .w_out_valid(b_out_valid), .w_out_ready(out_ready),
    .w_out_instr_32(b_out_instr), .w_out_pc_32(b_out_pc),
    .w_ctrl_10(b_ctrl), .w_op_type_6(b_op), .w_dest_addr_5(b_dest),
    .w_reg_write(b_reg_write), .w_count(b_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  ctrl;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        rw;
  } exp_t;

  exp_t tbl [17];
  exp_t cur, mon_e;
  exp_t sb [$];
  int   a_t [$];
  int   b_t [$];
  int   n_chk = 0, n_err = 0, cyc = 0, pops = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [31:0] i, logic [9:0] c, logic [5:0] o,
                              logic [4:0] d, logic w);
    exp_t e;
    e.instr = i; e.pc = 32'h0; e.ctrl = c; e.op = o; e.dest = d; e.rw = w;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (a_out_valid && out_ready) begin
        a_t.push_back(cyc);
        pops++;
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("instr", a_out_instr, mon_e.instr);
          check("pc", a_out_pc, mon_e.pc);
          check("ctrl", {22'd0, a_ctrl}, {22'd0, mon_e.ctrl});
          check("op_type", {26'd0, a_op}, {26'd0, mon_e.op});
          check("dest", {27'd0, a_dest}, {27'd0, mon_e.dest});
          check("reg_write", {31'd0, a_reg_write}, {31'd0, mon_e.rw});
        end
      end
      if (b_out_valid && out_ready) b_t.push_back(cyc);
      if (in_valid && a_in_ready) sb.push_back(cur);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input int idx, output bit acc);
    cur = tbl[idx];
    cur.pc = pc_ctr;
    instr = cur.instr;
    pc = pc_ctr;
    in_valid = 1'b1;
    @(negedge clk);
    acc = a_in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic push(input int idx);
    bit acc;
    for (int t = 0; t < 20; t++) begin
      offer(idx, acc);
      if (acc) return;
    end
    check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
    #1;
    check("drained", sb.size(), 32'd0);
    check("idle_valid", {31'd0, a_out_valid}, 32'd0);
  endtask

  task automatic gap_test(input int i0, input int i1, input int exp_a, input int exp_b);
    a_t.delete();
    b_t.delete();
    out_ready = 1'b1;
    push(i0);
    push(i1);
    cycles(6);
    check("gap_pops_a", a_t.size(), 32'd2);
    check("gap_pops_b", b_t.size(), 32'd2);
    if (a_t.size() == 2) check("gap_a", a_t[1] - a_t[0] - 1, exp_a);
    if (b_t.size() == 2) check("gap_b", b_t[1] - b_t[0] - 1, exp_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit   acc;
    time  t0;
    int   strm [13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 15, 16};
    int   fill [5]  = '{0, 2, 9, 16, 8};

    tbl[0]  = mk(32'h0022_1821, 10'h300, 6'h21, 5'd3,  1'b1); // ADDU $3,$1,$2
    tbl[1]  = mk(32'h8C25_0000, 10'h090, 6'h23, 5'd5,  1'b1); // LW $5,0($1)
    tbl[2]  = mk(32'h00A2_3020, 10'h200, 6'h20, 5'd6,  1'b1); // ADD $6,$5,$2
    tbl[3]  = mk(32'h0420_0004, 10'h004, 6'h00, 5'd0,  1'b0); // BLTZ
    tbl[4]  = mk(32'h0425_0004, 10'h001, 6'h00, 5'd0,  1'b0); // REGIMM rt=5
    tbl[5]  = mk(32'hFC00_0000, 10'h001, 6'h00, 5'd0,  1'b0); // opcode 0x3F
    tbl[6]  = mk(32'hAC22_0004, 10'h098, 6'h2B, 5'd0,  1'b0); // SW
    tbl[7]  = mk(32'h9027_0001, 10'h1D0, 6'h24, 5'd7,  1'b1); // LBU $7
    tbl[8]  = mk(32'h0C00_0100, 10'h082, 6'h03, 5'd31, 1'b1); // JAL
    tbl[9]  = mk(32'h0002_20C3, 10'h2A0, 6'h03, 5'd4,  1'b1); // SRA $4,$2,3
    tbl[10] = mk(32'h0022_0019, 10'h300, 6'h19, 5'd0,  1'b0); // MULTU
    tbl[11] = mk(32'h0000_0000, 10'h001, 6'h00, 5'd0,  1'b0); // SLL nop
    tbl[12] = mk(32'h2420_0005, 10'h380, 6'h09, 5'd0,  1'b0); // ADDIU $0
    tbl[13] = mk(32'h0080_F809, 10'h002, 6'h09, 5'd31, 1'b1); // JALR $31,$4
    tbl[14] = mk(32'h3C05_0001, 10'h090, 6'h0F, 5'd5,  1'b1); // LUI $5
    tbl[15] = mk(32'h1022_0003, 10'h004, 6'h04, 5'd0,  1'b0); // BEQ
    tbl[16] = mk(32'h0062_4804, 10'h220, 6'h04, 5'd9,  1'b1); // SLLV $9

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0;
    #12;
    check("rst_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_count", {29'd0, a_count}, 32'd0);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_ctrl", {22'd0, a_ctrl}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-edge latency into an empty queue
    push(0);
    cycles(1);
    check("latency_valid", {31'd0, a_out_valid}, 32'd1);
    check("latency_count", {29'd0, a_count}, 32'd0);
    drain();

    out_ready = 1'b1;
    t0 = $time;
    foreach (strm[i]) push(strm[i]);
    check("stream_cycles", 32'(($time - t0) / 10), 32'd13);
    drain();

    gap_test(1, 2, 1, 0);
    drain();
    gap_test(14, 2, 0, 0);
    drain();

    // Fill with the output register stalled
    out_ready = 1'b0;
    foreach (fill[i]) begin
      offer(fill[i], acc);
      check("fill_accept", {31'd0, acc}, 32'd1);
    end
    check("full_count", {29'd0, a_count}, 32'd4);
    check("full_in_ready", {31'd0, a_in_ready}, 32'd0);
    offer(15, acc);
    check("full_reject", {31'd0, acc}, 32'd0);
    check("full_count_hold", {29'd0, a_count}, 32'd4);
    drain();

    // Flush wins over a simultaneous push
    out_ready = 1'b0;
    push(0); push(2); push(9); push(16);
    check("pre_flush_count", {29'd0, a_count}, 32'd3);
    cur = tbl[15]; instr = cur.instr; pc = pc_ctr;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_count", {29'd0, a_count}, 32'd0);
    check("flush_valid", {31'd0, a_out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, a_in_ready}, 32'd1);
    out_ready = 1'b1;
    cycles(3);
    check("flush_lost_valid", {31'd0, a_out_valid}, 32'd0);
    check("flush_lost_count", {29'd0, a_count}, 32'd0);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    push(0); push(2); push(9);
    check("pre_rst_count", {29'd0, a_count}, 32'd2);
    check("pre_rst_valid", {31'd0, a_out_valid}, 32'd1);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, a_out_valid}, 32'd0);
    check("async_rst_count", {29'd0, a_count}, 32'd0);
    check("async_rst_instr", a_out_instr, 32'd0);
    check("async_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_valid", {31'd0, a_out_valid}, 32'd0);
    check("post_rst_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
